yrv_event_gen: RTL and testbench
================================

YRV_EVENT_GEN -- requirements
Module: yrv_event_gen

Interface
REQ-001 Parameter N_CH, default 2: number of independent event channels (1..16).
REQ-002 Parameter CNT_W, default 16: width of the period counter and period registers.
REQ-003 Port clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port reset  input  1  reset, asynchronous assert, active-high.
REQ-005 Port run  input  1  global count enable; low freezes all channel counters.
REQ-006 Port cfg_we  input  1  configuration write strobe, one cycle per write.
REQ-007 Port cfg_ch  input  $clog2(N_CH) (min 1)  channel index for cfg_we.
REQ-008 Port cfg_period  input  CNT_W  period P in clk cycles; 0 means disabled.
REQ-009 Port cfg_mode  input  2  00 PULSE, 01 LEVEL, 10 ONESHOT, 11 reserved (behaves as PULSE).
REQ-010 Port cfg_en  input  1  channel enable written with the configuration.
REQ-011 Port ack  input  N_CH  per-channel request acknowledge (LEVEL mode only).
REQ-012 Port ovr_clr  input  N_CH  per-channel overrun clear pulse.
REQ-013 Port req  output  N_CH  registered event request per channel (drives ei_req/nmi_req-style inputs).
REQ-014 Port overrun  output  N_CH  sticky flag: event fired while LEVEL request still pending.

Function
REQ-015 Per-channel states SHALL be IDLE, COUNT, PEND; IDLE when en=0 or P=0.
REQ-016 cfg_we with cfg_ch < N_CH SHALL load P, mode, en; zero counter; clear req and overrun; enter COUNT if en=1 and P!=0, else IDLE.
REQ-017 cfg_we with cfg_ch >= N_CH SHALL be ignored.
REQ-018 In COUNT/PEND with run=1, counter SHALL increment each cycle; on reaching P-1 it SHALL wrap to 0 and fire.
REQ-019 First fire SHALL make req high exactly P cycles after the cfg_we edge (run held 1); subsequent fires every P cycles.
REQ-020 P=1 in PULSE mode SHALL hold req high continuously from the first fire.
REQ-021 PULSE: req high for exactly the one cycle following each fire.
REQ-022 LEVEL: fire sets req and enters PEND; req stays high until ack sampled high, then clears next cycle and returns to COUNT.
REQ-023 LEVEL: fire while PEND and ack low SHALL set overrun; req stays high; counter keeps running.
REQ-024 LEVEL: fire and ack in same cycle SHALL leave req high (new event), overrun unchanged.
REQ-025 ONESHOT: first fire produces a one-cycle req pulse, then clears en and enters IDLE.
REQ-026 ack in PULSE/ONESHOT modes and ack on a non-pending channel SHALL be ignored.
REQ-027 run=0 SHALL freeze counters and states; req in LEVEL holds; PULSE req deasserts; ack still honoured.
REQ-028 ovr_clr SHALL clear overrun next cycle; simultaneous new overrun condition wins (flag stays set).
REQ-029 cfg_we to a channel in the same cycle as its fire SHALL take priority (no req produced).
REQ-030 Channels SHALL be fully independent; no cross-channel priority.

Reset
REQ-031 reset SHALL asynchronously force req=0, overrun=0, all counters=0, P=0, mode=PULSE, en=0 (all IDLE).
REQ-032 reset mid-PEND SHALL drop req within the reset assertion, not at the next edge.
REQ-033 After reset deassertion no req SHALL occur until a channel is configured.

Structure
REQ-034 Package yrv_event_gen_pkg SHALL hold the mode enum typedef, state enum typedef and default CNT_W/N_CH constants.
REQ-035 One sub-module yrv_event_gen_ch (single channel: counter, FSM, flags) SHALL be instantiated N_CH times in a generate loop; top holds only config decode.

Verification
REQ-036 Ch0 P=100 PULSE en, run=1 -> req[0] pulses at cycles 100,200,...,1000 after write, 10 pulses total.
REQ-037 Ch1 P=333 LEVEL, no ack -> req[1] rises at 333, stays high; overrun[1] sets at 666; ovr_clr[1] clears it.
REQ-038 Ch1 P=10 LEVEL, ack 3 cycles after each rise -> req high 4 cycles per event, overrun stays 0; ack coincident with fire -> req stays high.
REQ-039 Ch0 P=5 ONESHOT -> single pulse at cycle 5, none through cycle 100; run low cycles 2-4 delays pulse to cycle 8.
REQ-040 Ch0 P=1 PULSE -> req[0] constant high; reset asserted mid-stream -> req[0]=0 immediately, silent afterwards; cfg_ch=3 with N_CH=2 -> no effect.

Source files
------------

// File: rtl/yrv_event_gen_pkg.sv
// Shared types and defaults for the periodic event generator.
package yrv_event_gen_pkg;

    // Default channel count and counter width.
    localparam int DEF_N_CH  = 2;
    localparam int DEF_CNT_W = 16;

    // Channel operating modes as written through cfg_mode.
    typedef enum logic [1:0] {
        MODE_PULSE   = 2'b00,
        MODE_LEVEL   = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_t;

    // Per-channel FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_PEND  = 2'b10
    } state_t;

    // The reserved encoding is folded onto PULSE at write time so the
    // channel logic only ever sees the three defined modes.
    function automatic mode_t norm_mode(input logic [1:0] raw);
        mode_t m;
        case (raw)
            2'b01:   m = MODE_LEVEL;
            2'b10:   m = MODE_ONESHOT;
            default: m = MODE_PULSE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/yrv_event_gen_ch.sv
// One event channel: period counter, IDLE/COUNT/PEND FSM, req and
// sticky overrun flags. A configuration write always wins over a fire
// in the same cycle.
module yrv_event_gen_ch
    import yrv_event_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_period,
    input  logic [1:0]       wr_mode,
    input  logic             wr_en,
    input  logic             ack,
    input  logic             ovr_clr,
    output logic             req,
    output logic             overrun
);

    state_t           state_reg, state_next;
    mode_t            mode_reg, mode_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] period_reg, period_next;
    logic             en_reg, en_next;
    logic             req_reg, req_next;
    logic             ovr_reg, ovr_next;

    logic             active;
    logic             at_terminal;
    logic             fire;
    logic [CNT_W-1:0] cnt_inc;

    // Fire decode: the counter sits at P-1 while running in COUNT/PEND.
    always_comb begin
        active      = en_reg && ((state_reg == ST_COUNT) || (state_reg == ST_PEND));
        at_terminal = (cnt_reg == (period_reg - CNT_W'(1)));
        fire        = active && run && at_terminal;
        cnt_inc     = cnt_reg + CNT_W'(1);
    end

    // State and data registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            mode_reg   <= MODE_PULSE;
            cnt_reg    <= '0;
            period_reg <= '0;
            en_reg     <= 1'b0;
            req_reg    <= 1'b0;
            ovr_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mode_reg   <= mode_next;
            cnt_reg    <= cnt_next;
            period_reg <= period_next;
            en_reg     <= en_next;
            req_reg    <= req_next;
            ovr_reg    <= ovr_next;
        end
    end

    // Next-state logic: configuration load first, otherwise run the FSM.
    always_comb begin
        state_next  = state_reg;
        mode_next   = mode_reg;
        cnt_next    = cnt_reg;
        period_next = period_reg;
        en_next     = en_reg;
        req_next    = req_reg;
        ovr_next    = ovr_reg;

        if (wr) begin
            // A write restarts the channel from a clean slate.
            period_next = wr_period;
            mode_next   = norm_mode(wr_mode);
            en_next     = wr_en;
            cnt_next    = '0;
            req_next    = 1'b0;
            ovr_next    = 1'b0;
            state_next  = (wr_en && (wr_period != '0)) ? ST_COUNT : ST_IDLE;
        end else begin
            // Clear first so a simultaneous new overrun below wins.
            if (ovr_clr) begin
                ovr_next = 1'b0;
            end

            case (state_reg)
                ST_COUNT: begin
                    if (run) begin
                        cnt_next = fire ? '0 : cnt_inc;
                    end
                    case (mode_reg)
                        MODE_LEVEL: begin
                            req_next = fire;
                            if (fire) begin
                                state_next = ST_PEND;
                            end
                        end
                        MODE_ONESHOT: begin
                            req_next = fire;
                            if (fire) begin
                                en_next    = 1'b0;
                                state_next = ST_IDLE;
                            end
                        end
                        default: begin
                            // PULSE: req follows fire, so it drops when run is low.
                            req_next = fire;
                        end
                    endcase
                end

                ST_PEND: begin
                    // Only LEVEL channels reach PEND; req is held high here.
                    if (run) begin
                        cnt_next = fire ? '0 : cnt_inc;
                    end
                    if (fire) begin
                        req_next = 1'b1;
                        if (!ack) begin
                            ovr_next = 1'b1;
                        end
                    end else if (ack) begin
                        req_next   = 1'b0;
                        state_next = ST_COUNT;
                    end
                end

                ST_IDLE: begin
                    cnt_next = '0;
                    req_next = 1'b0;
                end

                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    req_next   = 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        req     = req_reg;
        overrun = ovr_reg;
    end

endmodule

// File: rtl/yrv_event_gen.sv
// Multi-channel periodic event generator. The top only decodes the
// configuration write onto the addressed channel; all timing lives in
// the per-channel instances, which are fully independent.
module yrv_event_gen
    import yrv_event_gen_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    run,
    input  logic                                    cfg_we,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                        cfg_period,
    input  logic [1:0]                              cfg_mode,
    input  logic                                    cfg_en,
    input  logic [N_CH-1:0]                         ack,
    input  logic [N_CH-1:0]                         ovr_clr,
    output logic [N_CH-1:0]                         req,
    output logic [N_CH-1:0]                         overrun
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0] ch_wr;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            // Out-of-range indices match no channel and are dropped.
            assign ch_wr[gi] = cfg_we && (cfg_ch == CH_W'(gi));

            yrv_event_gen_ch #(
                .CNT_W (CNT_W)
            ) u_ch (
                .clk       (clk),
                .reset     (reset),
                .run       (run),
                .wr        (ch_wr[gi]),
                .wr_period (cfg_period),
                .wr_mode   (cfg_mode),
                .wr_en     (cfg_en),
                .ack       (ack[gi]),
                .ovr_clr   (ovr_clr[gi]),
                .req       (req[gi]),
                .overrun   (overrun[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_yrv_event_gen.sv
// Bench for yrv_event_gen: table-driven scenarios, hand-written corner
// sequences and a randomized phase, all shadowed cycle by cycle by a
// behavioural model that counts running cycles since configuration.
// Three channels are used so that a 2-bit cfg_ch can address index 3,
// which must be ignored.
module tb_yrv_event_gen;
    import yrv_event_gen_pkg::*;

    localparam int N_CH  = 3;
    localparam int CNT_W = 16;
    localparam int CH_W  = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              run = 1'b0;
    logic              cfg_we = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_period = '0;
    logic [1:0]        cfg_mode = '0;
    logic              cfg_en = 1'b0;
    logic [N_CH-1:0]   ack = '0;
    logic [N_CH-1:0]   ovr_clr = '0;
    logic [N_CH-1:0]   req;
    logic [N_CH-1:0]   overrun;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;
    int cyc = 0;

    always #5 clk = ~clk;

    yrv_event_gen #(
        .N_CH  (N_CH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_mode   (cfg_mode),
        .cfg_en     (cfg_en),
        .ack        (ack),
        .ovr_clr    (ovr_clr),
        .req        (req),
        .overrun    (overrun)
    );

    // ---------------- behavioural reference model ----------------
    // An event fires whenever the number of running cycles since the
    // last configuration is a positive multiple of P.
    int m_p[N_CH];
    int m_mode[N_CH];
    int m_runs[N_CH];
    bit m_act[N_CH];
    bit m_req[N_CH];
    bit m_ovr[N_CH];
    bit m_pend[N_CH];

    function automatic void model_step(input int c);
        bit fire;
        bit new_ovr;
        if (cfg_we && (int'(cfg_ch) == c)) begin
            m_p[c]    = int'(cfg_period);
            m_mode[c] = (cfg_mode == 2'b11) ? 0 : int'(cfg_mode);
            m_runs[c] = 0;
            m_req[c]  = 1'b0;
            m_ovr[c]  = 1'b0;
            m_pend[c] = 1'b0;
            m_act[c]  = cfg_en && (cfg_period != 0);
            return;
        end
        fire = 1'b0;
        if (m_act[c] && run) begin
            m_runs[c]++;
            fire = ((m_runs[c] % m_p[c]) == 0);
        end
        new_ovr = m_ovr[c] && !ovr_clr[c];
        if (m_mode[c] == 1) begin
            if (fire) begin
                if (m_pend[c] && !ack[c]) new_ovr = 1'b1;
                m_req[c]  = 1'b1;
                m_pend[c] = 1'b1;
            end else if (m_pend[c] && ack[c]) begin
                m_req[c]  = 1'b0;
                m_pend[c] = 1'b0;
            end
        end else begin
            m_req[c] = fire;
            if (fire && (m_mode[c] == 2)) m_act[c] = 1'b0;
        end
        m_ovr[c] = new_ovr;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < N_CH; c++) begin
                m_p[c] = 0; m_mode[c] = 0; m_runs[c] = 0; m_act[c] = 0;
                m_req[c] = 0; m_ovr[c] = 0; m_pend[c] = 0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) model_step(c);
        end
    end

    logic [N_CH-1:0] exp_req;
    logic [N_CH-1:0] exp_ovr;

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int c = 0; c < N_CH; c++) begin
                exp_req[c] = m_req[c];
                exp_ovr[c] = m_ovr[c];
            end
            n_cmp++;
            if ((req !== exp_req) || (overrun !== exp_ovr)) begin
                n_fail++;
                $display("FAIL model_check t=%0t req=%b want %b overrun=%b want %b",
                         $time, req, exp_req, overrun, exp_ovr);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Write a channel config; on return cyc=0 marks the cycle after the write edge.
    task automatic cfg(input int ch, input int p, input int mode, input bit en);
        cfg_we     = 1'b1;
        cfg_ch     = CH_W'(ch);
        cfg_period = CNT_W'(p);
        cfg_mode   = 2'(mode);
        cfg_en     = en;
        tick();
        cfg_we = 1'b0;
        cyc    = 0;
        $display("cfg ch=%0d P=%0d mode=%0d en=%0d t=%0t", ch, p, mode, en, $time);
    endtask

    // Assert reset mid-cycle and confirm outputs drop before any clock edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check("reset_async_req", int'(req), 0);
        check("reset_async_ovr", int'(overrun), 0);
        ticks(2);
        #2 reset = 1'b0;
        ack     = '0;
        ovr_clr = '0;
        $display("reset t=%0t", $time);
    endtask

    typedef struct {
        int    ch;
        int    p;
        int    mode;
        bit    en;
        int    win;
        int    exp_first;
        int    exp_cnt;
        string name;
    } vec_t;

    vec_t vt[9];

    initial begin : watchdog
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int cnt;
        int hi;

        vt[0] = '{0, 100, 0, 1'b1, 1000, 100, 10, "pulse_p100"};
        vt[1] = '{0,   5, 2, 1'b1,  100,   5,  1, "oneshot_p5"};
        vt[2] = '{1,   7, 3, 1'b1,   50,   7,  7, "rsvd_as_pulse_p7"};
        vt[3] = '{0,   1, 0, 1'b1,   20,   1, 20, "pulse_p1"};
        vt[4] = '{1,   0, 0, 1'b1,   50,  -1,  0, "p0_disabled"};
        vt[5] = '{0,   4, 0, 1'b0,   50,  -1,  0, "en0_disabled"};
        vt[6] = '{3,   2, 0, 1'b1,   40,  -1,  0, "ch3_ignored"};
        vt[7] = '{2,   3, 1, 1'b1,   30,   3, 28, "level_p3_noack"};
        vt[8] = '{2,   6, 2, 1'b1,   60,   6,  1, "oneshot_p6_ch2"};

        // Power-on reset and reset state.
        ticks(3);
        #2 reset = 1'b0;
        chk_on = 1'b1;
        tick();
        check("reset_state_req", int'(req), 0);
        check("reset_state_ovr", int'(overrun), 0);
        ticks(20);
        check("idle_after_reset", int'(req), 0);

        // Table-driven scenarios: first req cycle and req-high cycle count.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            run = 1'b1;
            cfg(vt[i].ch, vt[i].p, vt[i].mode, vt[i].en);
            first = -1;
            cnt   = 0;
            for (int k = 1; k <= vt[i].win; k++) begin
                tick();
                if (|req) begin
                    cnt++;
                    if (first < 0) first = cyc;
                end
            end
            $display("vector %0d %s first=%0d count=%0d", i, vt[i].name, first, cnt);
            check({vt[i].name, "_first"}, first, vt[i].exp_first);
            check({vt[i].name, "_count"}, cnt, vt[i].exp_cnt);
        end

        // LEVEL P=333 without ack: rise, overrun at second fire, clear, re-set.
        do_reset();
        run = 1'b1;
        cfg(1, 333, 1, 1'b1);
        ticks(332);
        check("l333_pre_rise", int'(req[1]), 0);
        tick();
        check("l333_rise", int'(req[1]), 1);
        check("l333_ovr_clear", int'(overrun[1]), 0);
        ticks(332);
        check("l333_ovr_before_666", int'(overrun[1]), 0);
        tick();
        check("l333_ovr_at_666", int'(overrun[1]), 1);
        check("l333_req_held", int'(req[1]), 1);
        ticks(4);
        ovr_clr = 3'b010;
        tick();
        ovr_clr = '0;
        check("l333_ovr_cleared", int'(overrun[1]), 0);
        check("l333_req_after_clr", int'(req[1]), 1);
        ticks(327);
        check("l333_ovr_before_999", int'(overrun[1]), 0);
        tick();
        check("l333_ovr_at_999", int'(overrun[1]), 1);

        // LEVEL P=10 with ack three cycles after each rise.
        do_reset();
        run = 1'b1;
        cfg(1, 10, 1, 1'b1);
        for (int i = 0; i < 20 && !req[1]; i++) tick();
        check("l10_first_rise", cyc, 10);
        for (int ev = 0; ev < 4; ev++) begin
            hi = 0;
            for (int j = 0; j < 10; j++) begin
                if (req[1]) hi++;
                ack[1] = (j == 3);
                tick();
            end
            ack[1] = 1'b0;
            $display("level event %0d high_cycles=%0d", ev, hi);
            check("l10_high_len", hi, 4);
            check("l10_no_overrun", int'(overrun[1]), 0);
        end
        // Now at cycle 50 with a fresh pending event; ack lands on the next fire.
        check("l10_rise_50", int'(req[1]), 1);
        ticks(9);
        ack[1] = 1'b1;
        tick();
        ack[1] = 1'b0;
        check("l10_ack_with_fire_req", int'(req[1]), 1);
        check("l10_ack_with_fire_ovr", int'(overrun[1]), 0);
        tick();
        check("l10_still_pending", int'(req[1]), 1);
        ack[1] = 1'b1;
        tick();
        ack[1] = 1'b0;
        check("l10_acked", int'(req[1]), 0);

        // ONESHOT P=5 with run low for cycles 2-4: pulse moves to cycle 8.
        do_reset();
        run = 1'b1;
        cfg(0, 5, 2, 1'b1);
        tick();
        run = 1'b0;
        ticks(3);
        run = 1'b1;
        for (int k = 5; k <= 9; k++) begin
            tick();
            check($sformatf("oneshot_gap_c%0d", cyc), int'(req[0]), (cyc == 8) ? 1 : 0);
        end
        cnt = 0;
        for (int k = 10; k <= 100; k++) begin
            tick();
            if (req[0]) cnt++;
        end
        check("oneshot_gap_silent", cnt, 0);

        // Write to a channel in its fire cycle: the write wins.
        do_reset();
        run = 1'b1;
        cfg(0, 5, 0, 1'b1);
        ticks(4);
        cfg(0, 5, 0, 1'b1);
        check("cfg_beats_fire", int'(req[0]), 0);
        ticks(5);
        check("cfg_restart_fire", int'(req[0]), 1);

        // P=1 PULSE constant high, then reset mid-stream, then silence.
        do_reset();
        run = 1'b1;
        cfg(0, 1, 0, 1'b1);
        cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (!req[0]) cnt++;
        end
        check("p1_constant_high", cnt, 0);
        do_reset();
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (|req) cnt++;
        end
        check("silent_after_reset", cnt, 0);
        cfg(3, 2, 0, 1'b1);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (|req) cnt++;
        end
        check("ch3_no_effect", cnt, 0);

        // Randomized traffic; the per-cycle model check does the comparing.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            run     = ($urandom_range(0, 7) != 0);
            ack     = N_CH'($urandom) & N_CH'($urandom);
            ovr_clr = ($urandom_range(0, 15) == 0) ? N_CH'($urandom) : '0;
            if ($urandom_range(0, 39) == 0) begin
                cfg($urandom_range(0, 3), $urandom_range(0, 12),
                    $urandom_range(0, 3), ($urandom_range(0, 3) != 0));
            end else if ($urandom_range(0, 1499) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end
        ack     = '0;
        ovr_clr = '0;
        run     = 1'b0;
        tick();

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
